stream_regfile: RTL
===================

STREAM_REGFILE -- requirements
Module: stream_regfile

Interface
REQ-001 SHALL take parameter NPRIMES, default 2: RNS residues per coefficient.
REQ-002 SHALL take parameter NREGS, default `REG_NPOLY: polynomial registers stored.
REQ-003 SHALL take parameter NSLOTS, default `N_SLOTS: coefficients per polynomial.
REQ-004 SHALL take parameter LANES, default 4: coefficients per beat; NSLOTS divisible by LANES; BEATS = NSLOTS/LANES.
REQ-005 SHALL take parameter NRD, default 4: independent read stream ports.
REQ-006 SHALL provide clk, input, 1: the single clock; all state updates on posedge clk.
REQ-007 SHALL provide rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL provide rd_start[NRD], input, 1 each: request a read stream.
REQ-009 SHALL provide rd_idx[NRD], input, clog2(NREGS) each: source register, sampled with rd_start.
REQ-010 SHALL provide rd_ack[NRD], output, 1 each: one-cycle pulse when the request is accepted.
REQ-011 SHALL provide rd_valid[NRD] and rd_last[NRD], output, 1 each, and rd_ready[NRD], input, 1 each: read beat handshake.
REQ-012 SHALL provide rd_data[NRD][LANES][NPRIMES], output, rns_residue_t: read beat payload.
REQ-013 SHALL provide wr_start, input, 1; wr_idx, input, clog2(NREGS); wr_ack, output, 1: write stream request and accept pulse.
REQ-014 SHALL provide wr_valid, input, 1; wr_last, input, 1; wr_ready, output, 1; wr_data[LANES][NPRIMES], input, rns_residue_t: write beat handshake.
REQ-015 SHALL provide pending[NREGS], output, 1 each: register has a write stream in progress.

Function
REQ-016 Storage SHALL be mem[NREGS][NSLOTS][NPRIMES]; contents are not reset.
REQ-017 Each read port SHALL run FSM IDLE->STREAM->IDLE with a beat counter of width clog2(BEATS), minimum 1 bit.
REQ-018 In IDLE, a read request SHALL be accepted when pending[rd_idx] is 0 and wr_start for the same index is not being accepted that cycle; acceptance pulses rd_ack, latches rd_idx, clears beat and enters STREAM next cycle.
REQ-019 A refused read request SHALL produce no rd_ack; the requester holds or retries, and refusal does not stall other ports.
REQ-020 In STREAM, rd_valid SHALL be 1 and rd_data SHALL be the coefficients of mem[idx] at beat*LANES..beat*LANES+LANES-1, all primes.
REQ-021 rd_last SHALL be 1 when beat==BEATS-1; rd_data and rd_last SHALL hold stable while rd_valid&!rd_ready.
REQ-022 On rd_valid&rd_ready, beat SHALL increment; on the last beat the port SHALL return to IDLE. rd_start is ignored while in STREAM.
REQ-023 When rd_valid is 0, rd_data SHALL be all zero. First beat latency is 1 cycle after rd_ack.
REQ-024 The write port SHALL run FSM IDLE->FILL->IDLE; wr_ready SHALL be 1 exactly in FILL.
REQ-025 In IDLE, a write request SHALL be accepted when no read port in STREAM holds wr_idx and no read request to wr_idx is accepted that cycle; reads win a same-cycle same-index tie. Acceptance pulses wr_ack and sets pending[wr_idx].
REQ-026 In FILL, each wr_valid beat SHALL write wr_data into coefficients beat*LANES..+LANES-1 of the latched register, then increment beat.
REQ-027 The stream SHALL end on the beat where beat==BEATS-1, regardless of wr_last; that beat clears pending and returns to IDLE. An early wr_last is ignored.
REQ-028 Written data SHALL be visible to reads accepted in the cycle after pending clears.
REQ-029 Multiple read ports SHALL stream the same register concurrently without interaction.

Reset
REQ-030 With rst high at a posedge, all FSMs SHALL go to IDLE, beats to 0, pending to 0, and rd_ack, rd_valid, rd_last, rd_data, wr_ack, wr_ready to 0.
REQ-031 Reset mid-stream SHALL abandon the stream; a partially written register keeps its mixed contents and is not pending.

Verification
REQ-032 LANES=4, NSLOTS=16: write reg 3 with coeff c = 100+c over 4 beats, then read reg 3 with rd_ready held 1 -> 4 beats, rd_last on beat 3, data 100..115.
REQ-033 Read reg 3 with rd_ready toggling 1,0,1,0 -> data and rd_last stable during stalls; exactly 4 transfers.
REQ-034 Write reg 5 in progress (pending[5]=1) and rd_start to reg 5 -> no rd_ack until the cycle after the last write beat, then new data is read.
REQ-035 Same-cycle rd_start and wr_start to reg 2 -> rd_ack=1, wr_ack=0; old data is streamed, and the write is accepted after the read ends.
REQ-036 All 4 read ports start on reg 1 together -> 4 rd_ack pulses and identical beat streams.
REQ-037 Assert rst after write beat 1 of 4 -> pending 0, wr_ready 0 next cycle; a later read returns new data in coeffs 0..7 and old data in coeffs 8..15.

Source files
------------

// File: rtl/stream_regfile.sv
// stream_regfile: RNS polynomial register file with one write stream
// and NRD independent read streams, interlocked per register.
`ifndef REG_NPOLY
`define REG_NPOLY 8
`endif
`ifndef N_SLOTS
`define N_SLOTS 16
`endif

package stream_regfile_pkg;
    typedef logic [31:0] rns_residue_t;
endpackage

module stream_regfile
    import stream_regfile_pkg::*;
#(
    parameter int NPRIMES = 2,
    parameter int NREGS   = `REG_NPOLY,
    parameter int NSLOTS  = `N_SLOTS,
    parameter int LANES   = 4,
    parameter int NRD     = 4,
    localparam int IW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_start [NRD],
    input  logic [IW-1:0] rd_idx  [NRD],
    output logic         rd_ack   [NRD],
    output logic         rd_valid [NRD],
    output logic         rd_last  [NRD],
    input  logic         rd_ready [NRD],
    output rns_residue_t rd_data  [NRD][LANES][NPRIMES],
    input  logic         wr_start,
    input  logic [IW-1:0] wr_idx,
    output logic         wr_ack,
    input  logic         wr_valid,
    input  logic         wr_last,
    output logic         wr_ready,
    input  rns_residue_t wr_data  [LANES][NPRIMES],
    output logic         pending  [NREGS]
);

    localparam int BEATS = NSLOTS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    rns_residue_t mem [NREGS][NSLOTS][NPRIMES];

    rd_state_t     rd_state    [NRD];
    rd_state_t     rd_state_nx [NRD];
    logic [IW-1:0] rd_reg      [NRD];
    logic [IW-1:0] rd_reg_nx   [NRD];
    logic [BW-1:0] rd_beat     [NRD];
    logic [BW-1:0] rd_beat_nx  [NRD];
    logic          rd_accept   [NRD];

    wr_state_t     wr_state;
    wr_state_t     wr_state_nx;
    logic [IW-1:0] wr_reg;
    logic [IW-1:0] wr_reg_nx;
    logic [BW-1:0] wr_beat;
    logic [BW-1:0] wr_beat_nx;
    logic          wr_block;
    logic          wr_accept;

    // The beat count alone ends a write stream; wr_last is advisory.
    logic unused;
    assign unused = wr_last;

    function automatic logic [SW-1:0] slot(input logic [BW-1:0] beat,
                                           input int lane);
        return SW'(int'(beat) * LANES + lane);
    endfunction

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending[r] = (wr_state == W_FILL) && (wr_reg == IW'(r));
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_accept[p] = !rst && (rd_state[p] == R_IDLE) &&
                           rd_start[p] && !pending[rd_idx[p]];
        end
    end

    // Reads win a same-cycle tie on the same register.
    always_comb begin
        wr_block = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_state[p] == R_STREAM && rd_reg[p] == wr_idx) begin
                wr_block = 1'b1;
            end
            if (rd_accept[p] && rd_idx[p] == wr_idx) begin
                wr_block = 1'b1;
            end
        end
        wr_accept = !rst && (wr_state == W_IDLE) && wr_start && !wr_block;
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_state_nx[p] = rd_state[p];
            rd_reg_nx[p]   = rd_reg[p];
            rd_beat_nx[p]  = rd_beat[p];
            rd_ack[p]      = 1'b0;
            unique case (rd_state[p])
                R_IDLE: begin
                    if (rd_accept[p]) begin
                        rd_ack[p]      = 1'b1;
                        rd_state_nx[p] = R_STREAM;
                        rd_reg_nx[p]   = rd_idx[p];
                        rd_beat_nx[p]  = '0;
                    end
                end
                R_STREAM: begin
                    if (rd_ready[p]) begin
                        if (rd_beat[p] == LAST) begin
                            rd_state_nx[p] = R_IDLE;
                        end else begin
                            rd_beat_nx[p] = rd_beat[p] + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_valid[p] = (rd_state[p] == R_STREAM);
            rd_last[p]  = (rd_state[p] == R_STREAM) && (rd_beat[p] == LAST);
            for (int l = 0; l < LANES; l++) begin
                for (int q = 0; q < NPRIMES; q++) begin
                    rd_data[p][l][q] = '0;
                    if (rd_state[p] == R_STREAM) begin
                        rd_data[p][l][q] =
                            mem[rd_reg[p]][slot(rd_beat[p], l)][q];
                    end
                end
            end
        end
    end

    always_comb begin
        wr_state_nx = wr_state;
        wr_reg_nx   = wr_reg;
        wr_beat_nx  = wr_beat;
        wr_ack      = 1'b0;
        wr_ready    = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_ack      = 1'b1;
                    wr_state_nx = W_FILL;
                    wr_reg_nx   = wr_idx;
                    wr_beat_nx  = '0;
                end
            end
            W_FILL: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_beat == LAST) begin
                        wr_state_nx = W_IDLE;
                    end else begin
                        wr_beat_nx = wr_beat + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NRD; p++) begin
                rd_state[p] <= R_IDLE;
                rd_reg[p]   <= '0;
                rd_beat[p]  <= '0;
            end
            wr_state <= W_IDLE;
            wr_reg   <= '0;
            wr_beat  <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                rd_state[p] <= rd_state_nx[p];
                rd_reg[p]   <= rd_reg_nx[p];
                rd_beat[p]  <= rd_beat_nx[p];
            end
            wr_state <= wr_state_nx;
            wr_reg   <= wr_reg_nx;
            wr_beat  <= wr_beat_nx;
        end
    end

    // Storage has no reset; an abandoned write leaves mixed contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_state == W_FILL && wr_valid) begin
            for (int l = 0; l < LANES; l++) begin
                for (int q = 0; q < NPRIMES; q++) begin
                    mem[wr_reg][slot(wr_beat, l)][q] <= wr_data[l][q];
                end
            end
        end
    end

endmodule
